// File: rtl/seq_cla_addsub.sv
// Sequential carry-lookahead adder/subtractor: resolves one 4-bit group per clock
// with lookahead carries and ripples the group carry through a register.
module seq_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG    = WIDTH / GROUP;
  localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_next;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [GROUP-1:0]   p, g, s;
  logic [GROUP:0]     c;
  logic               accept, last;

  // Per-group propagate/generate and the lookahead carry unit.
  always_comb begin
    p = a_q[idx_q*GROUP +: GROUP] ^ b_q[idx_q*GROUP +: GROUP];
    g = a_q[idx_q*GROUP +: GROUP] & b_q[idx_q*GROUP +: GROUP];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = p ^ c[GROUP-1:0];
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    res_next = res_q;
    res_next[idx_q*GROUP +: GROUP] = s;
  end

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (idx_q == IDX_W'(NG - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    state <= state_next;
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_next;
      carry_q <= c[GROUP];
      idx_q   <= idx_q + 1'b1;
      // Results are published only once the final group is resolved.
      if (last) begin
        sum  <= res_next;
        cout <= c[GROUP];
        ovf  <= c[GROUP-1] ^ c[GROUP];
      end
    end
  end

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Scoreboard bench for seq_cla_addsub: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_cla_addsub;

  localparam int WIDTH = 16;
  localparam int NG    = 4;

  logic             clk = 1'b0;
  logic             rst, start, sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  result_t          exp_q[$];
  result_t          mon_e;
  int               tests = 0;
  int               fails = 0;
  int               done_count = 0;
  int               c0;
  logic [WIDTH-1:0] prev_sum;

  seq_cla_addsub #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got sum 0x%0h with no result pending", sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("result {cout,ovf,sum}", {14'd0, cout, ovf, sum},
              {14'd0, mon_e.cout, mon_e.ovf, mon_e.sum});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; start is sampled at the following posedge (edge k).
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic isub,
                       input logic push, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    result_t r;
    a = ia; b = ib; sub = isub; start = 1'b1;
    if (push) begin
      r.sum = es; r.cout = ec; r.ovf = eo;
      exp_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Starts just after edge k; returns at the negedge where done is seen.
  task automatic wait_done(input string name, input logic [WIDTH-1:0] es);
    bit got = 1'b0;
    for (int n = 1; n <= NG + 2 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check({name, "_latency"}, n, NG);
        check({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
      end else begin
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_sum_hold"}, {16'd0, sum}, {16'd0, prev_sum});
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done after %0d edges", name, NG);
    end
    prev_sum = es;
  endtask

  task automatic do_op(input string name, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic isub, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    issue(ia, ib, isub, 1'b1, es, ec, eo);
    wait_done(name, es);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; prev_sum = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_plain",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start while busy must be ignored.
    issue(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    c0 = done_count;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_single_done", done_count - c0, 1);
    check("ignored_start_sum", {16'd0, sum}, 32'h0002);
    prev_sum = 16'h0002;

    // Back-to-back: new start issued in the DONE cycle.
    issue(16'h0010, 16'h0020, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
    wait_done("b2b_first", 16'h0030);
    issue(16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    wait_done("b2b_second", 16'h1000);
    @(negedge clk);

    // Reset in the middle of an operation aborts it silently.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_op", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
    rst = 1'b0;
    prev_sum = '0;
    c0 = done_count;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", done_count - c0, 0);

    do_op("after_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_cla_addsub.md
Name: seq_cla_addsub

Overview:
- Multi-cycle carry-lookahead adder/subtractor built on the per-bit propagate/generate/sum (PGU/SU) datapath.
- Consumes the P/G terms one 4-bit group per clock, resolves the group carries with lookahead logic, and ripples the group carry through a register.
- Sits behind the PGU/SU cell as the control and sequencing side: latches operands on a start pulse, returns sum/carry/overflow with a done pulse.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
GROUP, 4, bits resolved per cycle by the lookahead carry unit; fixed at 4.
NG, WIDTH/GROUP (derived localparam), number of group cycles per operation.

Ports:
clk    in   1      rising-edge clock
rst    in   1      reset, synchronous, active-high
start  in   1      request; sampled only in IDLE or DONE
sub    in   1      0 = a+b, 1 = a-b; sampled with start
a      in   WIDTH  operand A; sampled with start
b      in   WIDTH  operand B; sampled with start
busy   out  1      high while an operation is in flight (RUN)
done   out  1      one-cycle pulse, result valid
sum    out  WIDTH  result; holds last result until the next done
cout   out  1      carry out of MSB; for sub, 1 = no borrow
ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE; busy, done, sum, cout, ovf <= 0.
  - Internal operand, carry and group-index registers are cleared.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch A <= a, B <= (sub ? ~b : b), carry <= sub, idx <= 0.
  - state <= RUN; busy <= 1.
  - start=0: remain in IDLE.
- RUN, each edge, for group idx (bits 4*idx+3 .. 4*idx):
  - p[i] = A[i]^B[i]; g[i] = A[i]&B[i].
  - Lookahead carries:
    - c1 = g0 | p0c0
    - c2 = g1 | p1g0 | p1p0c0
    - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
    - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
  - Sum bits: s[i] = p[i]^c[i] written into the internal result register.
  - carry <= c4; idx <= idx+1.
  - On the last group (idx = NG-1):
    - sum <= full result; cout <= c4; ovf <= c3 ^ c4.
    - done <= 1; busy <= 0; state <= DONE.
- Latency: start sampled at edge k, groups processed at edges k+1 .. k+NG.
  - done is high for exactly the one cycle after edge k+NG.
  - busy is high from after edge k until edge k+NG.
- DONE (one cycle):
  - done falls at the next edge.
  - If start=1 in DONE: the new operation is accepted exactly as in IDLE (back-to-back issue; next done NG+1 edges later).
  - Otherwise go to IDLE.
- start during RUN: ignored, with no effect on latched operands.
- a, b, sub changing during RUN: no effect.
- sum/cout/ovf change only on the done edge or on reset; they never show partial results.
- Wrap-around: the result is modulo 2^WIDTH; cout carries the lost bit.
- Reset mid-RUN: the operation is aborted, no done pulse, all outputs go to 0 at that edge.
- The next start after rst deasserts is accepted normally.

Test Plan:
- Plain add: a=0x1234, b=0x4321, sub=0, start at edge k -> busy high for edges k+1..k+4; done high only in the cycle after edge k+4; sum=0x5555, cout=0, ovf=0.
- Carry through all groups: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0. Repeat with a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Start while busy:
  - Issue 0x0001+0x0001.
  - Pulse start with a=0xAAAA, b=0x5555 two cycles later.
  - Expect exactly one done with sum=0x0002.
  - Expect no second done within 10 cycles.
- Back-to-back issue:
  - Hold start=1 with new operands (0x00FF+0x0F01) in the DONE cycle.
  - Expect a second done 5 edges later with sum=0x1000, cout=0.
  - The first result remains valid until then.
- Reset mid-op:
  - Assert rst at edge k+2 of an operation.
  - Expect busy=0, done=0, sum=0, cout=0, ovf=0 after that edge, and no done pulse.
  - A following 0x0003+0x0004 yields sum=0x0007.
